// File: rtl/note_msg_pkg.sv
// Shared constants for the note-message arbiter: message width, source indices
// and the arbiter FSM state encoding.
package note_msg_pkg;

    localparam int NOTE_MSG_W = 8;

    localparam logic [1:0] SRC_KEYBOARD = 2'd0;
    localparam logic [1:0] SRC_AUTOPLAY = 2'd1;
    localparam logic [1:0] SRC_AUX      = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/msg_fifo.sv
// Per-source message FIFO with synchronous push/pop; a push on a full FIFO is
// dropped (drop pulses) unless a pop frees a slot in the same cycle.
module msg_fifo
    import note_msg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = NOTE_MSG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/note_msg_arbiter.sv
// Round-robin merge of per-source note messages onto one valid/ready channel.
// Optional NOTE_MSG_ARB_DROP_CNT_EN adds per-source saturating drop counters.
module note_msg_arbiter
    import note_msg_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int MSG_W      = NOTE_MSG_W,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC-1:0]       src_stb,
    input  logic [NUM_SRC*MSG_W-1:0] src_msg,
    input  logic [NUM_SRC-1:0]       src_en,
    output logic                     out_valid,
    output logic [MSG_W-1:0]         out_msg,
    output logic [1:0]               out_src,
    input  logic                     out_ready,
    output logic [NUM_SRC-1:0]       src_ovf,
    input  logic                     ovf_clr
`ifdef NOTE_MSG_ARB_DROP_CNT_EN
    ,
    output logic [NUM_SRC*8-1:0]     drop_cnt
`endif
);

    localparam logic [7:0] GAP_INIT = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [NUM_SRC-1:0]    fifo_push;
    logic [NUM_SRC-1:0]    fifo_pop;
    logic [NUM_SRC-1:0]    fifo_full;
    logic [NUM_SRC-1:0]    fifo_empty;
    logic [NUM_SRC-1:0]    fifo_drop;
    logic [MSG_W-1:0]      fifo_dout [NUM_SRC];
    logic [3:0][MSG_W-1:0] dout4;
    logic [3:0]            nempty4;
    logic [3:0]            pop4;
    logic [1:0]            state;
    logic [1:0]            rr_ptr;
    logic [1:0]            sel;
    logic [7:0]            gap_cnt;
    logic                  grant;
    logic                  unused_full;

    // First non-empty source scanning upward from ptr+1, wrapping at NUM_SRC.
    function automatic logic [1:0] rr_pick(input logic [3:0] ne, input logic [1:0] ptr);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = 2'((int'(ptr) + k) % NUM_SRC);
            if (!found && ne[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign fifo_push = src_stb & src_en;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
        msg_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (MSG_W)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (fifo_push[i]),
            .pop   (fifo_pop[i]),
            .din   (src_msg[i*MSG_W +: MSG_W]),
            .dout  (fifo_dout[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i]),
            .drop  (fifo_drop[i])
        );
    end

    // Capture depends only on the FIFO's own drop decision; full is not needed here.
    assign unused_full = |fifo_full;

    always_comb begin
        nempty4 = '0;
        dout4   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            nempty4[i] = ~fifo_empty[i];
            dout4[i]   = fifo_dout[i];
        end
        sel   = rr_pick(nempty4, rr_ptr);
        grant = (state == ST_IDLE) && (nempty4 != 4'b0);
        pop4  = '0;
        if (grant) pop4[sel] = 1'b1;
    end

    assign fifo_pop = pop4[NUM_SRC-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_msg   <= '0;
            out_src   <= SRC_KEYBOARD;
            rr_ptr    <= 2'(NUM_SRC - 1);
            gap_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        out_valid <= 1'b1;
                        out_msg   <= dout4[sel];
                        out_src   <= sel;
                        rr_ptr    <= sel;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        gap_cnt   <= GAP_INIT;
                        state     <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 8'd0) state <= ST_IDLE;
                    else                 gap_cnt <= gap_cnt - 8'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) src_ovf <= '0;
        else     src_ovf <= (ovf_clr ? '0 : src_ovf) | fifo_drop;
    end

`ifdef NOTE_MSG_ARB_DROP_CNT_EN
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rst || ovf_clr)
                drop_cnt[i*8 +: 8] <= 8'd0;
            else if (fifo_drop[i] && drop_cnt[i*8 +: 8] != 8'hFF)
                drop_cnt[i*8 +: 8] <= drop_cnt[i*8 +: 8] + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_note_msg_arbiter.sv
// Scoreboard bench for note_msg_arbiter (NUM_SRC=2, FIFO_DEPTH=4, GAP_CYCLES=2).
module tb_note_msg_arbiter;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  src_stb;
    logic [15:0] src_msg;
    logic [1:0]  src_en;
    logic        out_valid;
    logic [7:0]  out_msg;
    logic [1:0]  out_src;
    logic        out_ready;
    logic [1:0]  src_ovf;
    logic        ovf_clr;
`ifdef NOTE_MSG_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] exp_q [$];

    note_msg_arbiter #(
        .NUM_SRC    (2),
        .MSG_W      (8),
        .FIFO_DEPTH (4),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_stb   (src_stb),
        .src_msg   (src_msg),
        .src_en    (src_en),
        .out_valid (out_valid),
        .out_msg   (out_msg),
        .out_src   (out_src),
        .out_ready (out_ready),
        .src_ovf   (src_ovf),
        .ovf_clr   (ovf_clr)
`ifdef NOTE_MSG_ARB_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_msg(input logic [1:0] s, input logic [7:0] m);
        exp_q.push_back({s, m});
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d messages still expected", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: compare on handshake, check hold stability and minimum gap.
    logic       prev_wait  = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_msg   = '0;
    logic [1:0] prev_src   = '0;
    logic       had_hs     = 1'b0;
    int         idle_cnt   = 0;

    always @(negedge clk) begin
        logic [9:0] e;
        if (rst) begin
            prev_wait  = 1'b0;
            prev_valid = 1'b0;
            had_hs     = 1'b0;
            idle_cnt   = 0;
        end else begin
            if (prev_wait && !out_valid) check("hold_valid", 32'(out_valid), 32'd1);
            if (out_valid) begin
                if (!prev_valid && had_hs) check("gap_min", 32'(idle_cnt >= GAP), 32'd1);
                if (prev_wait) check("hold_stable", {22'd0, out_src, out_msg}, {22'd0, prev_src, prev_msg});
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_msg", {22'd0, out_src, out_msg}, 32'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_src", 32'(out_src), 32'(e[9:8]));
                        check("out_msg", 32'(out_msg), 32'(e[7:0]));
                    end
                    had_hs   = 1'b1;
                    idle_cnt = 0;
                end
            end else begin
                idle_cnt++;
            end
            prev_wait  = out_valid && !out_ready;
            prev_valid = out_valid;
            prev_msg   = out_msg;
            prev_src   = out_src;
        end
    end

    initial begin
        rst = 1'b1; src_stb = '0; src_msg = '0; src_en = 2'b11; out_ready = 1'b1; ovf_clr = 1'b0;
        repeat (3) step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_msg", 32'(out_msg), 32'd0);
        check("rst_src", 32'(out_src), 32'd0);
        check("rst_ovf", 32'(src_ovf), 32'd0);
        rst = 1'b0;
        step();

        // Single source on src1: valid two edges after the strobe is presented.
        src_msg = {8'h3C, 8'h00}; src_stb = 2'b10; expect_msg(2'd1, 8'h3C);
        step();
        src_stb = '0;
        check("lat_edge1", 32'(out_valid), 32'd0);
        step();
        check("lat_edge2", 32'(out_valid), 32'd1);
        check("lat_msg", 32'(out_msg), 32'h3C);
        check("lat_src", 32'(out_src), 32'd1);
        wait_drain(50);
        repeat (6) step();

        // Contention: both sources strobe together three times.
        for (int k = 0; k < 3; k++) begin
            src_msg = {8'(8'h50 + k), 8'(8'h40 + k)}; src_stb = 2'b11;
            expect_msg(2'd0, 8'(8'h40 + k));
            expect_msg(2'd1, 8'(8'h50 + k));
            step();
        end
        src_stb = '0;
        wait_drain(100);
        repeat (6) step();

        // Backpressure: held for 20 cycles, released in the cycle ready rises.
        out_ready = 1'b0;
        src_msg = {8'h00, 8'h11}; src_stb = 2'b01; expect_msg(2'd0, 8'h11);
        step();
        src_stb = '0;
        repeat (20) step();
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_msg", 32'(out_msg), 32'h11);
        check("bp_src", 32'(out_src), 32'd0);
        out_ready = 1'b1;
        step();
        check("bp_release", 32'(out_valid), 32'd0);
        wait_drain(50);
        repeat (6) step();

        // Overflow on src0: one message in the output register, four in the FIFO.
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            src_msg = {8'h00, 8'(k)}; src_stb = 2'b01; expect_msg(2'd0, 8'(k));
            step();
        end
        src_stb = '0;
        check("ovf_none_full", 32'(src_ovf), 32'd0);
        src_msg = {8'h00, 8'h06}; src_stb = 2'b01;
        step();
        src_stb = '0;
        check("ovf_set", 32'(src_ovf), 32'd1);
`ifdef NOTE_MSG_ARB_DROP_CNT_EN
        check("drop_cnt0", 32'(drop_cnt[7:0]), 32'd1);
`endif
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(src_ovf), 32'd0);
`ifdef NOTE_MSG_ARB_DROP_CNT_EN
        check("drop_cnt_clr", 32'(drop_cnt[7:0]), 32'd0);
`endif
        // Push lands on the edge the full FIFO is popped (handshake, two GAP, IDLE).
        out_ready = 1'b1;
        step();
        step();
        step();
        src_msg = {8'h00, 8'h07}; src_stb = 2'b01; expect_msg(2'd0, 8'h07);
        step();
        src_stb = '0;
        wait_drain(100);
        check("ovf_push_pop_full", 32'(src_ovf), 32'd0);
        repeat (6) step();

        // src_en gating: queued entries drain, disabled strobe is ignored.
        out_ready = 1'b0;
        src_msg = {8'hA1, 8'h00}; src_stb = 2'b10; expect_msg(2'd1, 8'hA1);
        step();
        src_msg = {8'hA2, 8'h00}; expect_msg(2'd1, 8'hA2);
        step();
        src_stb = '0;
        src_en  = 2'b01;
        src_msg = {8'hA3, 8'h00}; src_stb = 2'b10;
        step();
        src_stb = '0;
        out_ready = 1'b1;
        wait_drain(100);
        repeat (10) step();
        check("en_no_extra", 32'(out_valid), 32'd0);
        src_en = 2'b11;

        // Reset mid-SEND with entries queued and an overflow flagged.
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            src_msg = {8'h00, 8'(8'h20 + k)}; src_stb = 2'b01;
            step();
        end
        src_msg = {8'h31, 8'h00}; src_stb = 2'b10;
        step();
        src_stb = '0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_ovf", 32'(src_ovf), 32'd1);
        rst = 1'b1;
        step();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ovf", 32'(src_ovf), 32'd0);
        check("mid_rst_msg", 32'(out_msg), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        src_msg = {8'h71, 8'h61}; src_stb = 2'b11;
        expect_msg(2'd0, 8'h61);
        expect_msg(2'd1, 8'h71);
        step();
        src_stb = '0;
        wait_drain(100);
        repeat (10) step();
        check("post_rst_idle", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
